// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and coefficient types for the polynomial datapaths.
package kyber_pkg;

  localparam int KYBER_Q          = 3329;
  localparam int QINV             = -3327;  // q^-1 mod 2^16, signed
  localparam int MONT_R2          = 1353;   // R^2 mod q, R = 2^16
  localparam int MONT_R           = 2285;   // R mod q
  localparam int MONT_R_NEG       = -1044;  // R mod q, centred representative
  localparam int N_COEFFS_DEFAULT = 256;

  typedef logic signed [15:0] coeff_t;
  typedef logic signed [31:0] wide_t;

endpackage

// File: rtl/mont_reduce_pipe.sv
// Two-stage registered Montgomery reduction: r = p * 2^-16 mod q, r in (-q, q),
// optionally folded into [0, q). Shared by tomont, basemul and invNTT datapaths.
module mont_reduce_pipe
  import kyber_pkg::*;
#(
  parameter bit NORMALIZE = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   in_valid,
  input  wide_t  in_p,
  output logic   out_valid,
  output coeff_t out_data
);

  wide_t  p2;
  coeff_t t2;
  logic   v2;

  wide_t  t_prod;
  wide_t  diff;
  coeff_t r_raw;
  coeff_t r_fix;

  // t keeps only the low 16 bits of p*QINV: a two's-complement wrap, so the
  // subtraction below clears the low half of p exactly.
  always_comb begin
    t_prod = in_p * QINV;
    diff   = p2 - t2 * KYBER_Q;
    r_raw  = coeff_t'(diff >>> 16);
    r_fix  = r_raw;
    if (NORMALIZE && (r_raw < 0)) begin
      r_fix = coeff_t'(r_raw + KYBER_Q);
    end
  end

  // NOTE: the data registers are reset along with the valids so out_data is
  // never X, even before the first coefficient has passed through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v2        <= 1'b0;
      p2        <= '0;
      t2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      v2        <= in_valid;
      p2        <= in_p;
      t2        <= t_prod[15:0];
      out_valid <= v2;
      out_data  <= r_fix;
    end
  end

endmodule

// File: rtl/poly_tomont.sv
// Streaming normal-to-Montgomery converter: out = a * 2^16 mod q per coefficient,
// three-stage pipe with valid/ready on both sides and a per-polynomial index.
module poly_tomont
  import kyber_pkg::*;
#(
  parameter int  N_COEFFS  = N_COEFFS_DEFAULT,
  parameter bit  NORMALIZE = 1'b0,
  localparam int IDX_W     = $clog2(N_COEFFS)
) (
  input  logic             clk,
  input  logic             reset,
  input  coeff_t           in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output coeff_t           out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFFS - 1);

  logic  adv;
  logic  accept;
  logic  out_hs;
  wide_t p1_next;
  wide_t p1;
  logic  v1;

  // The whole pipe moves in lockstep; a bubble inside does not open in_ready.
  assign adv      = !out_valid || out_ready;
  assign in_ready = reset && adv;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign out_last = out_valid && (out_idx == LAST_IDX);
  assign p1_next  = in_data * MONT_R2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (adv) begin
      v1 <= accept;
      p1 <= p1_next;
    end
  end

  mont_reduce_pipe #(
    .NORMALIZE (NORMALIZE)
  ) u_reduce (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (v1),
    .in_p      (p1),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= out_hs && out_last;
      if (out_hs) begin
        out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
      end
    end
  end

endmodule
